// File: rtl/rv32i_types.sv
// Shared RV32 decode types for the rename/dispatch slice: opcodes, M-extension
// funct3 codes, reservation-station selector and the decoded-field bundle.
package rv32i_types;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_B_IMM  = 7'b0010011;
  localparam logic [6:0] OP_B_REG  = 7'b0110011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MUL = 2'd1,
    RS_DIV = 2'd2
  } rs_sel_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decode_info_t;

  // Opcodes whose instructions produce a destination register value.
  function automatic logic is_rd_writer(input logic [6:0] opcode);
    logic w;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_B_IMM, OP_B_REG: w = 1'b1;
      default:                     w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rd_decoder.sv
// Combinational decode of the instruction-queue head: field extraction,
// immediate formation, reservation-station selection and free-list demand.
module rd_decoder
  import rv32i_types::*;
(
  input  logic [31:0]  inst,
  output decode_info_t decode,
  output rs_sel_e      sel,
  output logic         need_pd
);

  logic [6:0]  opcode_s;
  logic [31:0] imm_s;

  assign opcode_s = inst[6:0];

  // Immediate formation by instruction format; R-type and unknown yield zero.
  always_comb begin
    imm_s = 32'd0;
    case (opcode_s)
      OP_LUI, OP_AUIPC:            imm_s = {inst[31:12], 12'd0};
      OP_JAL:                      imm_s = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_B_IMM:  imm_s = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BR:                       imm_s = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default:                     imm_s = 32'd0;
    endcase
  end

  // Pack decoded fields and pick the target station; only M-extension
  // register ops leave the ALU station.
  always_comb begin
    decode.opcode = opcode_s;
    decode.funct3 = inst[14:12];
    decode.funct7 = inst[31:25];
    decode.rd     = inst[11:7];
    decode.rs1    = inst[19:15];
    decode.rs2    = inst[24:20];
    decode.imm    = imm_s;
    sel           = RS_ALU;
    if ((opcode_s == OP_B_REG) && (inst[31:25] == F7_MULDIV)) begin
      case (inst[14:12])
        F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU: sel = RS_MUL;
        F3_DIV, F3_DIVU, F3_REM, F3_REMU:     sel = RS_DIV;
        default:                              sel = RS_ALU;
      endcase
    end else begin
      sel = RS_ALU;
    end
    need_pd = is_rd_writer(opcode_s) && (inst[11:7] != 5'd0);
  end

endmodule

// File: rtl/rename_dispatch_reg.sv
// Rename one instruction per cycle into a one-entry dispatch register that
// issues to a single target reservation station and snoops the CDB while held.
module rename_dispatch_reg
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int NUM_RS        = 3,
  parameter int CDB_PORTS     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [31:0]                        inst,
  input  logic                               is_iqueue_empty,
  output logic                               iqueue_dequeue,
  input  logic [PHYS_REG_BITS-1:0]           phys_reg,
  input  logic                               is_free_list_empty,
  output logic                               fl_dequeue,
  output logic [4:0]                         rs1,
  output logic [4:0]                         rs2,
  input  logic [PHYS_REG_BITS-1:0]           ps1,
  input  logic [PHYS_REG_BITS-1:0]           ps2,
  input  logic                               ps1_valid,
  input  logic                               ps2_valid,
  output logic                               rat_we,
  output logic [4:0]                         rat_rd,
  output logic [PHYS_REG_BITS-1:0]           rat_pd,
  input  logic                               rob_full,
  input  logic [ROB_IDX_BITS-1:0]            rob_num,
  output logic                               rob_enqueue,
  input  logic [CDB_PORTS-1:0]               cdb_valid,
  input  logic [CDB_PORTS*PHYS_REG_BITS-1:0] cdb_pd,
  input  logic [NUM_RS-1:0]                  rs_full,
  output logic [NUM_RS-1:0]                  rs_issue,
  output decode_info_t                       out_decode,
  output logic [PHYS_REG_BITS-1:0]           out_pd,
  output logic [PHYS_REG_BITS-1:0]           out_ps1,
  output logic [PHYS_REG_BITS-1:0]           out_ps2,
  output logic                               out_ps1_valid,
  output logic                               out_ps2_valid,
  output logic [ROB_IDX_BITS-1:0]            out_rob_num
);

  localparam logic [PHYS_REG_BITS-1:0] PD_ZERO = {PHYS_REG_BITS{1'b0}};

  // True when any valid CDB port broadcasts the given tag.
  function automatic logic cdb_hit(
    input logic [CDB_PORTS-1:0]               v,
    input logic [CDB_PORTS*PHYS_REG_BITS-1:0] pds,
    input logic [PHYS_REG_BITS-1:0]           tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      hit = hit | (v[k] & (pds[k*PHYS_REG_BITS +: PHYS_REG_BITS] == tag));
    end
    return hit;
  endfunction

  decode_info_t dec_info_s;
  rs_sel_e      dec_sel_s;
  logic         need_pd_s;

  logic         issue_s;
  logic         fire_s;
  logic         cap_ps1_valid_s;
  logic         cap_ps2_valid_s;
  logic         hold_ps1_valid_s;
  logic         hold_ps2_valid_s;
  logic [NUM_RS-1:0] rs_issue_s;

  logic                      out_valid_r;
  rs_sel_e                   out_sel_r;
  decode_info_t              out_decode_r;
  logic [PHYS_REG_BITS-1:0]  out_pd_r;
  logic [PHYS_REG_BITS-1:0]  out_ps1_r;
  logic [PHYS_REG_BITS-1:0]  out_ps2_r;
  logic                      out_ps1_valid_r;
  logic                      out_ps2_valid_r;
  logic [ROB_IDX_BITS-1:0]   out_rob_num_r;

  rd_decoder u_rd_decoder (
    .inst    (inst),
    .decode  (dec_info_s),
    .sel     (dec_sel_s),
    .need_pd (need_pd_s)
  );

  // Issue/fire handshake; flush and reset kill every strobe, and only the
  // held instruction's own station can stall it.
  always_comb begin
    issue_s    = 1'b0;
    fire_s     = 1'b0;
    rs_issue_s = {NUM_RS{1'b0}};
    if (!rst && !flush && out_valid_r && !rs_full[out_sel_r]) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (!rst && !flush && !is_iqueue_empty && !rob_full &&
        (!need_pd_s || !is_free_list_empty) && (!out_valid_r || issue_s)) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
    if (issue_s) begin
      rs_issue_s[out_sel_r] = 1'b1;
    end else begin
      rs_issue_s = {NUM_RS{1'b0}};
    end
  end

  // Source-ready bits: at capture merge RAT, same-cycle CDB and tag zero;
  // while held, sticky-set on any matching broadcast.
  always_comb begin
    cap_ps1_valid_s  = ps1_valid | cdb_hit(cdb_valid, cdb_pd, ps1) | (ps1 == PD_ZERO);
    cap_ps2_valid_s  = ps2_valid | cdb_hit(cdb_valid, cdb_pd, ps2) | (ps2 == PD_ZERO);
    hold_ps1_valid_s = out_ps1_valid_r | cdb_hit(cdb_valid, cdb_pd, out_ps1_r);
    hold_ps2_valid_s = out_ps2_valid_r | cdb_hit(cdb_valid, cdb_pd, out_ps2_r);
  end

  // Rename-side strobes toward queue, free list, RAT and ROB.
  always_comb begin
    iqueue_dequeue = fire_s;
    rob_enqueue    = fire_s;
    fl_dequeue     = 1'b0;
    rat_we         = 1'b0;
    rat_rd         = 5'd0;
    rat_pd         = PD_ZERO;
    rs1            = 5'd0;
    rs2            = 5'd0;
    if (fire_s && need_pd_s) begin
      fl_dequeue = 1'b1;
      rat_we     = 1'b1;
      rat_rd     = dec_info_s.rd;
      rat_pd     = phys_reg;
    end else begin
      fl_dequeue = 1'b0;
      rat_we     = 1'b0;
    end
    if (!rst) begin
      rs1 = inst[19:15];
      rs2 = inst[24:20];
    end else begin
      rs1 = 5'd0;
      rs2 = 5'd0;
    end
  end

  // Dispatch register: reset clears all, flush drops, fire loads (also
  // back-to-back after an issue), issue alone empties, otherwise hold and snoop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r     <= 1'b0;
      out_sel_r       <= RS_ALU;
      out_decode_r    <= '0;
      out_pd_r        <= PD_ZERO;
      out_ps1_r       <= PD_ZERO;
      out_ps2_r       <= PD_ZERO;
      out_ps1_valid_r <= 1'b0;
      out_ps2_valid_r <= 1'b0;
      out_rob_num_r   <= {ROB_IDX_BITS{1'b0}};
    end else if (flush) begin
      out_valid_r     <= 1'b0;
    end else if (fire_s) begin
      out_valid_r     <= 1'b1;
      out_sel_r       <= dec_sel_s;
      out_decode_r    <= dec_info_s;
      out_pd_r        <= need_pd_s ? phys_reg : PD_ZERO;
      out_ps1_r       <= ps1;
      out_ps2_r       <= ps2;
      out_ps1_valid_r <= cap_ps1_valid_s;
      out_ps2_valid_r <= cap_ps2_valid_s;
      out_rob_num_r   <= rob_num;
    end else if (issue_s) begin
      out_valid_r     <= 1'b0;
    end else begin
      out_ps1_valid_r <= hold_ps1_valid_s;
      out_ps2_valid_r <= hold_ps2_valid_s;
    end
  end

  assign rs_issue      = rs_issue_s;
  assign out_decode    = out_decode_r;
  assign out_pd        = out_pd_r;
  assign out_ps1       = out_ps1_r;
  assign out_ps2       = out_ps2_r;
  assign out_ps1_valid = out_ps1_valid_r;
  assign out_ps2_valid = out_ps2_valid_r;
  assign out_rob_num   = out_rob_num_r;

endmodule

// File: tb/tb_rename_dispatch_reg.sv
// Directed bench for rename_dispatch_reg with hand-computed expectations.
module tb_rename_dispatch_reg;
  import rv32i_types::*;

  localparam int PRB = 6;
  localparam int RIB = 5;
  localparam int NRS = 3;
  localparam int CDP = 1;

  localparam logic [31:0] I_ADD  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] I_MUL  = {7'b0000001, 5'd1, 5'd1, 3'b000, 5'd5, 7'b0110011};
  localparam logic [31:0] I_DIV  = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd6, 7'b0110011};
  localparam logic [31:0] I_SW   = {7'b0000000, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] I_ADDI0 = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, flush, is_iqueue_empty, iqueue_dequeue;
  logic [31:0] inst;
  logic [PRB-1:0] phys_reg, ps1, ps2, rat_pd, out_pd, out_ps1, out_ps2;
  logic is_free_list_empty, fl_dequeue, ps1_valid, ps2_valid, rat_we;
  logic [4:0] rs1, rs2, rat_rd;
  logic rob_full, rob_enqueue, out_ps1_valid, out_ps2_valid;
  logic [RIB-1:0] rob_num, out_rob_num;
  logic [CDP-1:0] cdb_valid;
  logic [CDP*PRB-1:0] cdb_pd;
  logic [NRS-1:0] rs_full, rs_issue;
  decode_info_t out_decode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rename_dispatch_reg #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB), .NUM_RS(NRS), .CDB_PORTS(CDP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .inst(inst), .is_iqueue_empty(is_iqueue_empty),
    .iqueue_dequeue(iqueue_dequeue), .phys_reg(phys_reg), .is_free_list_empty(is_free_list_empty),
    .fl_dequeue(fl_dequeue), .rs1(rs1), .rs2(rs2), .ps1(ps1), .ps2(ps2), .ps1_valid(ps1_valid),
    .ps2_valid(ps2_valid), .rat_we(rat_we), .rat_rd(rat_rd), .rat_pd(rat_pd), .rob_full(rob_full),
    .rob_num(rob_num), .rob_enqueue(rob_enqueue), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .rs_full(rs_full), .rs_issue(rs_issue), .out_decode(out_decode), .out_pd(out_pd),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_ps1_valid(out_ps1_valid),
    .out_ps2_valid(out_ps2_valid), .out_rob_num(out_rob_num)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a queue head plus RAT/free-list/ROB state.
  task automatic present(input logic [31:0] i, input logic [PRB-1:0] pr,
                         input logic [PRB-1:0] p1, input logic v1,
                         input logic [PRB-1:0] p2, input logic v2,
                         input logic [RIB-1:0] rn);
    inst = i; phys_reg = pr; ps1 = p1; ps1_valid = v1; ps2 = p2; ps2_valid = v2;
    rob_num = rn; is_iqueue_empty = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inst = I_ADD; is_iqueue_empty = 1'b0; phys_reg = 6'd7;
    is_free_list_empty = 1'b0; ps1 = 6'd4; ps2 = 6'd5; ps1_valid = 1'b1; ps2_valid = 1'b0;
    rob_full = 1'b0; rob_num = 5'd2; cdb_valid = 1'b0; cdb_pd = '0; rs_full = 3'b000;
    tick(); tick();
    check("rst_iq_deq", 64'(iqueue_dequeue), 64'd0);
    check("rst_rs1", 64'(rs1), 64'd0);
    check("rst_out_pd", 64'(out_pd), 64'd0);
    rst = 1'b0;

    // add x3,x1,x2
    present(I_ADD, 6'd7, 6'd4, 1'b1, 6'd5, 1'b0, 5'd2);
    check("add_iq_deq", 64'(iqueue_dequeue), 64'd1);
    check("add_fl_deq", 64'(fl_dequeue), 64'd1);
    check("add_rob_enq", 64'(rob_enqueue), 64'd1);
    check("add_rat_we", 64'(rat_we), 64'd1);
    check("add_rat_rd", 64'(rat_rd), 64'd3);
    check("add_rat_pd", 64'(rat_pd), 64'd7);
    check("add_rs1", 64'(rs1), 64'd1);
    check("add_rs2", 64'(rs2), 64'd2);
    tick(); is_iqueue_empty = 1'b1; #1;
    check("add_rs_issue", 64'(rs_issue), 64'b001);
    check("add_out_pd", 64'(out_pd), 64'd7);
    check("add_out_ps1", 64'(out_ps1), 64'd4);
    check("add_ps1_v", 64'(out_ps1_valid), 64'd1);
    check("add_ps2_v", 64'(out_ps2_valid), 64'd0);
    check("add_rob_num", 64'(out_rob_num), 64'd2);
    check("add_dec_rd", 64'(out_decode.rd), 64'd3);
    tick();
    check("add_drained", 64'(rs_issue), 64'b000);

    // mul held by full MUL station, then add behind it
    rs_full = 3'b010;
    present(I_MUL, 6'd8, 6'd4, 1'b1, 6'd4, 1'b1, 5'd3);
    tick();
    present(I_ADD, 6'd9, 6'd4, 1'b1, 6'd5, 1'b1, 5'd4);
    check("mul_stall_issue", 64'(rs_issue), 64'b000);
    check("mul_stall_iq", 64'(iqueue_dequeue), 64'd0);
    check("mul_out_pd", 64'(out_pd), 64'd8);
    tick();
    check("mul_still_held", 64'(out_pd), 64'd8);
    rs_full = 3'b000; #1;
    check("mul_issue", 64'(rs_issue), 64'b010);
    check("b2b_iq_deq", 64'(iqueue_dequeue), 64'd1);
    check("b2b_rat_pd", 64'(rat_pd), 64'd9);
    tick(); is_iqueue_empty = 1'b1; rs_full = 3'b110; #1;
    check("b2b_add_issue", 64'(rs_issue), 64'b001);
    check("b2b_out_pd", 64'(out_pd), 64'd9);
    check("b2b_rob_num", 64'(out_rob_num), 64'd4);
    tick(); rs_full = 3'b000;

    // div with ps1=9 pending, snooped while DIV station full
    rs_full = 3'b100;
    present(I_DIV, 6'd10, 6'd9, 1'b0, 6'd0, 1'b0, 5'd5);
    tick(); is_iqueue_empty = 1'b1; #1;
    check("div_held", 64'(rs_issue), 64'b000);
    check("div_ps1_v0", 64'(out_ps1_valid), 64'd0);
    check("div_tag0_v", 64'(out_ps2_valid), 64'd1);
    cdb_valid = 1'b1; cdb_pd = 6'd9;
    tick(); cdb_valid = 1'b0; cdb_pd = 6'd0; #1;
    check("div_snoop_v", 64'(out_ps1_valid), 64'd1);
    check("div_snoop_hold", 64'(rs_issue), 64'b000);
    rs_full = 3'b000; #1;
    check("div_issue", 64'(rs_issue), 64'b100);
    tick();

    // capture-cycle bypass
    cdb_valid = 1'b1; cdb_pd = 6'd9;
    present(I_ADD, 6'd12, 6'd9, 1'b0, 6'd11, 1'b0, 5'd6);
    tick(); is_iqueue_empty = 1'b1; cdb_valid = 1'b0; cdb_pd = 6'd0; #1;
    check("byp_ps1_v", 64'(out_ps1_valid), 64'd1);
    check("byp_ps2_v", 64'(out_ps2_valid), 64'd0);
    tick();

    // no-rd instructions with free list empty
    is_free_list_empty = 1'b1;
    present(I_SW, 6'd13, 6'd1, 1'b1, 6'd2, 1'b1, 5'd7);
    check("sw_iq_deq", 64'(iqueue_dequeue), 64'd1);
    check("sw_fl_deq", 64'(fl_dequeue), 64'd0);
    check("sw_rat_we", 64'(rat_we), 64'd0);
    tick();
    present(I_ADDI0, 6'd13, 6'd0, 1'b1, 6'd0, 1'b1, 5'd8);
    check("sw_out_pd", 64'(out_pd), 64'd0);
    check("sw_issue", 64'(rs_issue), 64'b001);
    check("addi0_iq_deq", 64'(iqueue_dequeue), 64'd1);
    check("addi0_rat_we", 64'(rat_we), 64'd0);
    tick();
    present(I_ADD, 6'd13, 6'd1, 1'b1, 6'd2, 1'b1, 5'd9);
    check("addi0_out_pd", 64'(out_pd), 64'd0);
    check("add_fl_empty_iq", 64'(iqueue_dequeue), 64'd0);
    is_free_list_empty = 1'b0;
    tick(); is_iqueue_empty = 1'b1; tick();

    // flush over a held instruction
    rs_full = 3'b010;
    present(I_MUL, 6'd14, 6'd4, 1'b1, 6'd4, 1'b1, 5'd10);
    tick();
    present(I_ADD, 6'd15, 6'd4, 1'b1, 6'd5, 1'b1, 5'd11);
    rs_full = 3'b000; flush = 1'b1; #1;
    check("flush_iq", 64'(iqueue_dequeue), 64'd0);
    check("flush_fl", 64'(fl_dequeue), 64'd0);
    check("flush_rob", 64'(rob_enqueue), 64'd0);
    check("flush_rat", 64'(rat_we), 64'd0);
    check("flush_issue", 64'(rs_issue), 64'b000);
    tick(); flush = 1'b0; is_iqueue_empty = 1'b1; #1;
    check("flush_empty", 64'(rs_issue), 64'b000);

    // reset mid-hold
    rs_full = 3'b010;
    present(I_MUL, 6'd16, 6'd3, 1'b1, 6'd3, 1'b1, 5'd12);
    tick();
    check("pre_rst_pd", 64'(out_pd), 64'd16);
    rst = 1'b1; #1;
    check("rst_comb_iq", 64'(iqueue_dequeue), 64'd0);
    check("rst_comb_rob", 64'(rob_enqueue), 64'd0);
    tick(); rst = 1'b0; is_iqueue_empty = 1'b1; rs_full = 3'b000; #1;
    check("rst_hold_issue", 64'(rs_issue), 64'b000);
    check("rst_hold_pd", 64'(out_pd), 64'd0);
    check("rst_hold_ps1", 64'(out_ps1), 64'd0);
    check("rst_hold_ps1v", 64'(out_ps1_valid), 64'd0);
    check("rst_hold_rob", 64'(out_rob_num), 64'd0);
    check("rst_hold_dec", 64'(out_decode), 64'd0);

    // ROB full blocks rename
    rob_full = 1'b1;
    present(I_ADD, 6'd17, 6'd1, 1'b1, 6'd2, 1'b1, 5'd13);
    check("robf_iq", 64'(iqueue_dequeue), 64'd0);
    check("robf_rob", 64'(rob_enqueue), 64'd0);
    check("robf_fl", 64'(fl_dequeue), 64'd0);
    check("robf_rat", 64'(rat_we), 64'd0);
    tick();
    check("robf_issue", 64'(rs_issue), 64'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_dispatch_reg.md
Name: rename_dispatch_reg

Overview:
- Registered, parametrised successor to the combinational rename/dispatch stage.
- Renames one instruction per cycle from the instruction queue using the free list, RAT and ROB, then captures the result in a one-entry dispatch register.
- The dispatch register issues to exactly one of NUM_RS reservation stations. Stalls depend only on the target station being full, not on all stations.
- While an instruction is held, it snoops the CDB, so source-ready bits never go stale. A flush input discards in-flight work.

Parameters:
PHYS_REG_BITS, 6, physical register index width
ROB_IDX_BITS, 5, ROB tag width
NUM_RS, 3, number of reservation stations; index 0 = ALU, 1 = MUL, 2 = DIV; must be ≥3
CDB_PORTS, 1, number of CDB broadcast ports snooped

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard held instruction; suppress all dequeues this cycle
inst  in  32  head of instruction queue
is_iqueue_empty  in  1  instruction queue empty
iqueue_dequeue  out  1  pop instruction queue (comb)
phys_reg  in  PHYS_REG_BITS  free-list head
is_free_list_empty  in  1  free list empty
fl_dequeue  out  1  pop free list (comb)
rs1, rs2  out  5 each  RAT read addresses (comb, = inst[19:15], inst[24:20])
ps1, ps2  in  PHYS_REG_BITS each  RAT read data
ps1_valid, ps2_valid  in  1 each  RAT ready bits
rat_we  out  1  RAT write (comb)
rat_rd  out  5  RAT write arch reg
rat_pd  out  PHYS_REG_BITS  RAT write phys reg
rob_full  in  1  ROB full
rob_num  in  ROB_IDX_BITS  ROB tail tag
rob_enqueue  out  1  allocate ROB entry (comb)
cdb_valid  in  CDB_PORTS  broadcast valid per port
cdb_pd  in  CDB_PORTS*PHYS_REG_BITS  broadcast phys reg per port
rs_full  in  NUM_RS  per-station full
rs_issue  out  NUM_RS  one-hot station write strobe (comb from register)
out_decode  out  decode_info_t  held decoded fields
out_pd, out_ps1, out_ps2  out  PHYS_REG_BITS each  held physical tags
out_ps1_valid, out_ps2_valid  out  1 each  held ready bits (CDB-updated)
out_rob_num  out  ROB_IDX_BITS  held ROB tag

Behaviour:
- Classify the instruction into sel:
  - opcode op_b_reg, funct7=0000001, funct3 in {mul, mulh, mulhsu, mulhu} → sel=1
  - same opcode and funct7, funct3 in {div, divu, rem, remu} → sel=2
  - all else → sel=0
- need_pd = writes-rd opcode and rd≠x0. Opcodes without rd (branch, store) or rd=x0 do not pop the free list; pd=0 and rat_we=0.
- issue = out_valid & ~rs_full[out_sel]; rs_issue[out_sel]=issue, other bits 0.
- fire = ~flush & ~is_iqueue_empty & ~rob_full & (~need_pd | ~is_free_list_empty) & (~out_valid | issue).
- On fire:
  - iqueue_dequeue=1, rob_enqueue=1.
  - fl_dequeue=need_pd, rat_we=need_pd, rat_rd=rd, rat_pd=phys_reg.
  - Next edge loads the register: out_valid=1, sel, decode, pd, ps1/ps2, rob_num.
- Ready bits:
  - At capture, psN_valid is set if the RAT bit is set OR any cdb_valid[k] has cdb_pd[k]==psN (same-cycle bypass).
  - While held, a matching broadcast sets the bit.
  - Tag 0 is always valid.
- issue without fire: out_valid←0 next edge. issue with fire: back-to-back replacement, no bubble.
- Held instruction and payload remain stable while its station is full. Other stations' full flags do not matter.
- flush: out_valid←0 next edge; iqueue/free-list/ROB/RAT strobes and rs_issue are 0 that cycle. flush wins over issue.
- Reset: out_valid=0, every out_* field=0; comb outputs 0 while rst asserted.
- Throughput: 1 instr/cycle. Latency: queue head to rs_issue = 1 cycle minimum.

Decomposition:
- rv32i_types holds:
  - decode_info_t
  - opcode/funct3 constants
  - rs_sel_e (RS_ALU=0, RS_MUL=1, RS_DIV=2)
  - the function is_rd_writer(opcode)
- One sub-module, rd_decoder: combinational, inst → decode_info_t, sel, need_pd.
- Everything else lives in rename_dispatch_reg.

Test Plan:
- add x3,x1,x2; free list phys_reg=7; RAT ps1=4 valid, ps2=5 invalid; rob_num=2 → same cycle: dequeues, rat_we with rd=3/pd=7. Next cycle: rs_issue=001, out_pd=7, out_ps2_valid=0, out_rob_num=2.
- mul x5,x1,x1 held with rs_full=010, then add queued → add not dequeued. Later rs_full=000 → rs_issue=010, add fires the same cycle, and add issues on rs_issue=001 the next cycle.
- Held div with ps1=9 not valid, rs_full[2]=1, cdb_valid=1, cdb_pd=9 → out_ps1_valid=1 next cycle. Broadcast of pd=9 in the capture cycle → captured valid=1.
- sw or addi x0 with free list empty → fires, fl_dequeue=0, rat_we=0, out_pd=0.
- Held instruction plus flush=1 while iqueue non-empty → no dequeues, rs_issue=0, out_valid=0 next cycle.
- rst asserted mid-hold → out_valid and all out_* =0 next edge. rob_full=1 → no strobes.
